// File: rtl/writeback_queue_multi.sv
// In-order write-back queue: arbitrates load-unit and ALU results into a DEPTH-entry
// FIFO, drains one entry per cycle to register-file port A, and offers B/C forwarding lookup.
module writeback_queue_multi #(
  parameter int REG_WIDTH  = 34,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_alu_valid,
  output logic                    o_alu_ready,
  input  logic [ADDR_WIDTH-1:0]   i_alu_addr,
  input  logic [REG_WIDTH-1:0]    i_alu_data,
  input  logic                    i_mem_valid,
  output logic                    o_mem_ready,
  input  logic [ADDR_WIDTH-1:0]   i_mem_addr,
  input  logic [REG_WIDTH-1:0]    i_mem_data,
  input  logic                    i_stall_wb,
  output logic [ADDR_WIDTH-1:0]   o_address_reg_a,
  output logic                    o_wenable_reg_a,
  output logic [REG_WIDTH-1:0]    o_writedata_reg_a,
  input  logic [ADDR_WIDTH-1:0]   i_lookup_addr_b,
  input  logic [ADDR_WIDTH-1:0]   i_lookup_addr_c,
  output logic                    o_hit_b,
  output logic                    o_hit_c,
  output logic [REG_WIDTH-1:0]    o_fwd_data_b,
  output logic [REG_WIDTH-1:0]    o_fwd_data_c,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [REG_WIDTH-1:0]  data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic                  full;
  logic                  pop;
  logic                  push;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [REG_WIDTH-1:0]  push_data;
  logic [PW-1:0]         lk_idx;

  // Ready is derived only from occupancy and the drain, never from the producer's own valid.
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    o_empty     = (count_q == '0);
    pop         = !o_empty && !i_stall_wb;
    o_mem_ready = !full || pop;
    o_alu_ready = o_mem_ready && !i_mem_valid;
    push        = o_mem_ready && (i_mem_valid || i_alu_valid);
    push_addr   = i_mem_valid ? i_mem_addr : i_alu_addr;
    push_data   = i_mem_valid ? i_mem_data : i_alu_data;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    o_wenable_reg_a   = pop;
    o_address_reg_a   = '0;
    o_writedata_reg_a = '0;
    if (!o_empty) begin
      o_address_reg_a   = addr_q[rd_ptr_q];
      o_writedata_reg_a = data_q[rd_ptr_q];
    end
  end

  // Scan oldest to youngest so a later match overwrites an earlier one.
  always_comb begin
    o_hit_b      = 1'b0;
    o_hit_c      = 1'b0;
    o_fwd_data_b = '0;
    o_fwd_data_c = '0;
    lk_idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      lk_idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (addr_q[lk_idx] == i_lookup_addr_b) begin
          o_hit_b      = 1'b1;
          o_fwd_data_b = data_q[lk_idx];
        end
        if (addr_q[lk_idx] == i_lookup_addr_c) begin
          o_hit_c      = 1'b1;
          o_fwd_data_c = data_q[lk_idx];
        end
      end
    end
  end

  assign o_count = count_q;

endmodule

// File: tb/tb_writeback_queue_multi.sv
// Directed bench for writeback_queue_multi: expected register-file writes go into a
// scoreboard queue; a negedge monitor checks every write against it in order.
module tb_writeback_queue_multi;

  localparam int RW = 34;
  localparam int AW = 5;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_alu_valid, i_mem_valid, i_stall_wb;
  logic          o_alu_ready, o_mem_ready;
  logic [AW-1:0] i_alu_addr, i_mem_addr, i_lookup_addr_b, i_lookup_addr_c;
  logic [RW-1:0] i_alu_data, i_mem_data;
  logic [AW-1:0] o_address_reg_a;
  logic          o_wenable_reg_a;
  logic [RW-1:0] o_writedata_reg_a;
  logic          o_hit_b, o_hit_c;
  logic [RW-1:0] o_fwd_data_b, o_fwd_data_c;
  logic [2:0]    o_count;
  logic          o_empty;

  typedef struct {
    logic [AW-1:0] a;
    logic [RW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  writeback_queue_multi #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
    .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .i_stall_wb(i_stall_wb),
    .o_address_reg_a(o_address_reg_a), .o_wenable_reg_a(o_wenable_reg_a),
    .o_writedata_reg_a(o_writedata_reg_a),
    .i_lookup_addr_b(i_lookup_addr_b), .i_lookup_addr_c(i_lookup_addr_c),
    .o_hit_b(o_hit_b), .o_hit_c(o_hit_c),
    .o_fwd_data_b(o_fwd_data_b), .o_fwd_data_c(o_fwd_data_c),
    .o_count(o_count), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [RW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic alu(input logic v, input logic [AW-1:0] a, input logic [RW-1:0] d);
    i_alu_valid = v;
    i_alu_addr  = a;
    i_alu_data  = d;
  endtask

  // Write monitor: every enabled write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && o_wenable_reg_a === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr=%0d data=0x%0h expected no write", o_address_reg_a, o_writedata_reg_a);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (o_address_reg_a !== w.a || o_writedata_reg_a !== w.d) begin
          failures++;
          $display("FAIL wr_order: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   o_address_reg_a, o_writedata_reg_a, w.a, w.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    i_stall_wb = 1'b0;
    i_mem_valid = 1'b0; i_mem_addr = '0; i_mem_data = '0;
    alu(1'b0, '0, '0);
    i_lookup_addr_b = '0;
    i_lookup_addr_c = '0;
    edge1();
    edge1();
    rst = 1'b0;
    #2;
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_wen", 64'(o_wenable_reg_a), 64'd0);
    chk("rst_alu_rdy", 64'(o_alu_ready), 64'd1);
    chk("rst_mem_rdy", 64'(o_mem_ready), 64'd1);
    chk("rst_hit_b", 64'(o_hit_b), 64'd0);
    chk("rst_wdata", 64'(o_writedata_reg_a), 64'd0);

    // single ALU write
    alu(1'b1, 5'd3, 34'h2_DEAD_BEEF);
    i_lookup_addr_b = 5'd3;
    expect_wr(5'd3, 34'h2_DEAD_BEEF);
    edge1();
    alu(1'b0, '0, '0);
    #2;
    chk("single_wen", 64'(o_wenable_reg_a), 64'd1);
    chk("single_addr", 64'(o_address_reg_a), 64'd3);
    chk("single_data", 64'(o_writedata_reg_a), 64'h2_DEAD_BEEF);
    chk("single_hit_b", 64'(o_hit_b), 64'd1);
    chk("single_fwd_b", 64'(o_fwd_data_b), 64'h2_DEAD_BEEF);
    edge1();
    #2;
    chk("single_empty", 64'(o_empty), 64'd1);
    chk("single_hit_gone", 64'(o_hit_b), 64'd0);

    // simultaneous producers: load unit first
    i_mem_valid = 1'b1; i_mem_addr = 5'd10; i_mem_data = 34'h100;
    alu(1'b1, 5'd11, 34'h200);
    #2;
    chk("arb_alu_rdy", 64'(o_alu_ready), 64'd0);
    chk("arb_mem_rdy", 64'(o_mem_ready), 64'd1);
    expect_wr(5'd10, 34'h100);
    edge1();
    i_mem_valid = 1'b0;
    #2;
    chk("arb_alu_rdy2", 64'(o_alu_ready), 64'd1);
    expect_wr(5'd11, 34'h200);
    edge1();
    alu(1'b0, '0, '0);
    edge1();
    #2;
    chk("arb_empty", 64'(o_empty), 64'd1);

    // stall fills the queue; fifth result waits for the first pop
    i_stall_wb = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu(1'b1, AW'(i), RW'(34'h1000 + i));
      #2;
      chk("fill_rdy", 64'(o_alu_ready), 64'd1);
      expect_wr(AW'(i), RW'(34'h1000 + i));
      edge1();
    end
    alu(1'b1, 5'd5, 34'h1005);
    #2;
    chk("full_count", 64'(o_count), 64'd4);
    chk("full_alu_rdy", 64'(o_alu_ready), 64'd0);
    chk("full_mem_rdy", 64'(o_mem_ready), 64'd0);
    chk("full_wen", 64'(o_wenable_reg_a), 64'd0);
    edge1();
    #2;
    chk("full_hold", 64'(o_count), 64'd4);
    i_stall_wb = 1'b0;
    #1;
    chk("release_rdy", 64'(o_alu_ready), 64'd1);
    chk("release_wen", 64'(o_wenable_reg_a), 64'd1);
    expect_wr(5'd5, 34'h1005);
    edge1();
    alu(1'b0, '0, '0);
    #2;
    chk("pushpop_count", 64'(o_count), 64'd4);
    for (int i = 0; i < 4; i++) edge1();
    #2;
    chk("drain_empty", 64'(o_empty), 64'd1);

    // youngest match forwarding
    i_stall_wb = 1'b1;
    i_lookup_addr_c = 5'd7;
    alu(1'b1, 5'd7, 34'h11);
    expect_wr(5'd7, 34'h11);
    edge1();
    alu(1'b1, 5'd7, 34'h22);
    expect_wr(5'd7, 34'h22);
    edge1();
    alu(1'b0, '0, '0);
    #2;
    chk("fwd_hit_c", 64'(o_hit_c), 64'd1);
    chk("fwd_data_c", 64'(o_fwd_data_c), 64'h22);
    chk("fwd_count", 64'(o_count), 64'd2);
    i_stall_wb = 1'b0;
    edge1();
    #2;
    chk("fwd_after_pop1", 64'(o_fwd_data_c), 64'h22);
    chk("fwd_hit_after_pop1", 64'(o_hit_c), 64'd1);
    edge1();
    #2;
    chk("fwd_hit_after_pop2", 64'(o_hit_c), 64'd0);
    chk("fwd_data_after_pop2", 64'(o_fwd_data_c), 64'd0);

    // reset discards queued entries
    i_stall_wb = 1'b1;
    i_lookup_addr_b = 5'd20;
    for (int i = 0; i < 3; i++) begin
      alu(1'b1, AW'(20 + i), RW'(34'h300 + i));
      edge1();
    end
    alu(1'b0, '0, '0);
    #2;
    chk("prerst_count", 64'(o_count), 64'd3);
    chk("prerst_hit_b", 64'(o_hit_b), 64'd1);
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    i_stall_wb = 1'b0;
    #2;
    chk("postrst_empty", 64'(o_empty), 64'd1);
    chk("postrst_count", 64'(o_count), 64'd0);
    chk("postrst_wen", 64'(o_wenable_reg_a), 64'd0);
    chk("postrst_hit_b", 64'(o_hit_b), 64'd0);
    chk("postrst_rdy", 64'(o_alu_ready), 64'd1);
    for (int i = 0; i < 4; i++) edge1();
    #2;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
